// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the dual-issue controller: FSM encodings and queue entry layout.
// No logic lives here; the top and the pairing checker both import it.
package issue_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] ISS_RUN   = 2'd0;
  localparam logic [1:0] ISS_DRAIN = 2'd1;
  localparam logic [1:0] ISS_WAIT  = 2'd2;

  // Per-entry control fields; the wide payload is stored beside it so PAYLOAD_W stays a parameter.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rj;
    logic [REG_W-1:0] rk;
    logic             is_alu;
    logic             is_priv;
  } iq_meta_t;

  // RAW between an older producer and a younger consumer; r0 never creates a dependency.
  function automatic logic raw_hazard(input logic [REG_W-1:0] older_rd,
                                      input logic [REG_W-1:0] younger_rj,
                                      input logic [REG_W-1:0] younger_rk);
    return (older_rd != '0) && ((older_rd == younger_rj) || (older_rd == younger_rk));
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Decides whether the two oldest queue entries may issue together this cycle.
// Purely combinational, no backpressure of its own.
module issue_pair_check
  import issue_ctrl_pkg::*;
(
  input  logic             two_valid,
  input  logic [REG_W-1:0] e0_rd,
  input  logic             e0_is_alu,
  input  logic             e0_is_priv,
  input  logic [REG_W-1:0] e1_rj,
  input  logic [REG_W-1:0] e1_rk,
  input  logic             e1_is_alu,
  input  logic             e1_is_priv,
  output logic             pair_ok
);

  logic both_alu;
  logic no_priv;
  logic hazard;

  assign both_alu = e0_is_alu && e1_is_alu;
  assign no_priv  = !e0_is_priv && !e1_is_priv;
  assign hazard   = raw_hazard(e0_rd, e1_rj, e1_rk);
  assign pair_ok  = two_valid && both_alu && no_priv && !hazard;

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue queue: issues 0-2 entries in order, one cycle after enqueue, serialising priv ops.
// in_ready drops once fewer than two slots are free; out_ready must accept every valid slot.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 128
)(
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       flush,
  input  logic [1:0]                 in_valid,
  output logic                       in_ready,
  input  logic [PAYLOAD_W-1:0]       in_payload0,
  input  logic [PAYLOAD_W-1:0]       in_payload1,
  input  logic [REG_W-1:0]           in_rd0,
  input  logic [REG_W-1:0]           in_rd1,
  input  logic [REG_W-1:0]           in_rj0,
  input  logic [REG_W-1:0]           in_rj1,
  input  logic [REG_W-1:0]           in_rk0,
  input  logic [REG_W-1:0]           in_rk1,
  input  logic                       in_is_alu0,
  input  logic                       in_is_alu1,
  input  logic                       in_is_priv0,
  input  logic                       in_is_priv1,
  output logic [1:0]                 out_valid,
  input  logic                       out_ready,
  output logic [PAYLOAD_W-1:0]       out_payload0,
  output logic [PAYLOAD_W-1:0]       out_payload1,
  output logic [REG_W-1:0]           out_rd0,
  output logic [REG_W-1:0]           out_rd1,
  output logic [REG_W-1:0]           out_rj0,
  output logic [REG_W-1:0]           out_rj1,
  output logic [REG_W-1:0]           out_rk0,
  output logic [REG_W-1:0]           out_rk1,
  input  logic                       backend_empty,
  input  logic                       priv_done,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  iq_meta_t             meta_q    [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W-1:0] occ;
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] hidx0, hidx1, tidx0, tidx1;
  iq_meta_t         e0, e1, wr_meta0, wr_meta1;
  logic             has1, has2, pair_ok;
  logic             enq, pop;

  assign occ      = tail_q - head_q;
  assign count    = occ;
  assign state    = state_q;
  assign has1     = (occ != '0);
  assign has2     = (occ >= PTR_W'(2));
  assign in_ready = (occ <= PTR_W'(DEPTH - 2));

  // Index arithmetic in IDX_W bits wraps naturally, so a pair may straddle DEPTH-1 -> 0.
  assign hidx0 = head_q[IDX_W-1:0];
  assign hidx1 = hidx0 + IDX_W'(1);
  assign tidx0 = tail_q[IDX_W-1:0];
  assign tidx1 = tidx0 + IDX_W'(1);

  assign e0 = meta_q[hidx0];
  assign e1 = meta_q[hidx1];

  assign wr_meta0 = '{rd: in_rd0, rj: in_rj0, rk: in_rk0, is_alu: in_is_alu0, is_priv: in_is_priv0};
  assign wr_meta1 = '{rd: in_rd1, rj: in_rj1, rk: in_rk1, is_alu: in_is_alu1, is_priv: in_is_priv1};

  issue_pair_check u_pair_check (
    .two_valid  (has2),
    .e0_rd      (e0.rd),
    .e0_is_alu  (e0.is_alu),
    .e0_is_priv (e0.is_priv),
    .e1_rj      (e1.rj),
    .e1_rk      (e1.rk),
    .e1_is_alu  (e1.is_alu),
    .e1_is_priv (e1.is_priv),
    .pair_ok    (pair_ok)
  );

  always_comb begin
    out_valid = 2'b00;
    state_d   = state_q;
    case (state_q)
      ISS_RUN: begin
        if (has1 && e0.is_priv) begin
          state_d = ISS_DRAIN;
        end else if (has1) begin
          out_valid = {pair_ok, 1'b1};
        end
      end
      // The priv entry stays at head throughout DRAIN, so E0 is always the one issued.
      ISS_DRAIN: begin
        out_valid = {1'b0, backend_empty};
        if (backend_empty && out_ready) begin
          state_d = ISS_WAIT;
        end
      end
      ISS_WAIT: begin
        if (priv_done) begin
          state_d = ISS_RUN;
        end
      end
      default: state_d = ISS_RUN;
    endcase
  end

  assign out_payload0 = payload_q[hidx0];
  assign out_payload1 = payload_q[hidx1];
  assign out_rd0      = e0.rd;
  assign out_rj0      = e0.rj;
  assign out_rk0      = e0.rk;
  assign out_rd1      = e1.rd;
  assign out_rj1      = e1.rj;
  assign out_rk1      = e1.rk;

  assign enq = in_ready && in_valid[0] && !flush;
  assign pop = out_ready && out_valid[0] && !flush;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      head_q  <= '0;
      tail_q  <= '0;
      state_q <= ISS_RUN;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      state_q <= ISS_RUN;
    end else begin
      state_q <= state_d;
      if (pop) begin
        head_q <= head_q + PTR_W'(1) + PTR_W'(out_valid[1]);
      end
      if (enq) begin
        tail_q <= tail_q + PTR_W'(1) + PTR_W'(in_valid[1]);
      end
    end
  end

  // Storage needs no reset: occupancy comes solely from the pointers.
  always_ff @(posedge aclk) begin
    if (enq) begin
      payload_q[tidx0] <= in_payload0;
      meta_q[tidx0]    <= wr_meta0;
      if (in_valid[1]) begin
        payload_q[tidx1] <= in_payload1;
        meta_q[tidx1]    <= wr_meta1;
      end
    end
  end

endmodule
